// File: rtl/boot_loader_pkg.sv
// Shared state encodings, polarity constants and bus widths for the boot loader.
package boot_loader_pkg;

    localparam logic [2:0] BL_HDR  = 3'd0;
    localparam logic [2:0] BL_LOAD = 3'd1;
    localparam logic [2:0] BL_HOLD = 3'd2;
    localparam logic [2:0] BL_RUN  = 3'd3;
    localparam logic [2:0] BL_ERR  = 3'd4;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic RST_DISABLE   = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    function automatic logic [INST_ADDR_W-1:0] word_to_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid is combinational on the 4th byte.
// No storage beyond the partial word, so the caller's ready gates acceptance directly.
module boot_loader_byte_packer
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_ready,
    output logic [INST_W-1:0] word,
    output logic              word_valid
);

    logic [23:0] asm_q;
    logic [1:0]  byte_idx;
    logic        accept;

    assign accept     = in_valid && in_ready;
    assign word       = {asm_q, in_data};
    assign word_valid = accept && (byte_idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            asm_q    <= 24'd0;
            byte_idx <= 2'd0;
        end else if (clr) begin
            asm_q    <= 24'd0;
            byte_idx <= 2'd0;
        end else if (accept) begin
            asm_q    <= {asm_q[15:0], in_data};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Loads a length-prefixed big-endian image into instruction ROM, then releases the CPU after a guard.
// One write per word, one cycle after its last byte; rx_ready drops once the image is complete.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int MAX_WORDS   = 1024,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   rom_we,
    output logic [INST_ADDR_W-1:0] rom_addr,
    output logic [INST_W-1:0]      rom_wdata,
    output logic                   cpu_rst,
    output logic                   boot_done,
    output logic                   boot_err,
    output logic [CNT_W-1:0]       words_loaded
);

    logic [2:0]        state;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [31:0]       hold_cnt;
    logic [INST_W-1:0] pk_word;
    logic              pk_word_valid;
    logic              pk_clr;
    logic              hdr_bad;
    logic              hdr_zero;

    // Outside HDR/LOAD no bytes flow, so any leftover partial word is dropped.
    assign pk_clr = (state != BL_HDR) && (state != BL_LOAD);

    boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pk_clr),
        .in_data    (rx_data),
        .in_valid   (rx_valid),
        .in_ready   (rx_ready),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    assign hdr_bad  = ((pk_word >> CNT_W) != 32'd0) ||
                      (32'(pk_word[CNT_W-1:0]) > 32'(MAX_WORDS));
    assign hdr_zero = (pk_word[CNT_W-1:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state        <= BL_HDR;
            rx_ready     <= 1'b0;
            rom_we       <= WRITE_DISABLE;
            rom_addr     <= '0;
            rom_wdata    <= '0;
            cpu_rst      <= RST_ENABLE;
            boot_done    <= 1'b0;
            boot_err     <= 1'b0;
            words_loaded <= '0;
            hdr_cnt      <= '0;
            hold_cnt     <= 32'd0;
        end else begin
            rom_we <= WRITE_DISABLE;
            case (state)
                BL_HDR: begin
                    rx_ready <= 1'b1;
                    hold_cnt <= 32'd0;
                    if (pk_word_valid) begin
                        hdr_cnt <= pk_word[CNT_W-1:0];
                        if (hdr_bad) begin
                            state    <= BL_ERR;
                            rx_ready <= 1'b0;
                            boot_err <= 1'b1;
                        end else if (hdr_zero) begin
                            state    <= BL_HOLD;
                            rx_ready <= 1'b0;
                        end else begin
                            state <= BL_LOAD;
                        end
                    end
                end
                BL_LOAD: begin
                    if (pk_word_valid) begin
                        rom_we       <= WRITE_ENABLE;
                        rom_wdata    <= pk_word;
                        rom_addr     <= word_to_addr(32'(words_loaded));
                        words_loaded <= words_loaded + CNT_W'(1);
                        // Close the gate with the last write so no byte past the image is taken.
                        if (words_loaded + CNT_W'(1) == hdr_cnt)
                            rx_ready <= 1'b0;
                    end else if (words_loaded == hdr_cnt) begin
                        state    <= BL_HOLD;
                        rx_ready <= 1'b0;
                        hold_cnt <= 32'd0;
                    end
                end
                BL_HOLD: begin
                    rx_ready <= 1'b0;
                    if (hold_cnt + 32'd1 >= 32'(HOLD_CYCLES)) begin
                        state     <= BL_RUN;
                        cpu_rst   <= RST_DISABLE;
                        boot_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                BL_RUN: begin
                    rx_ready <= 1'b0;
                end
                BL_ERR: begin
                    rx_ready <= 1'b0;
                end
                default: begin
                    state    <= BL_ERR;
                    rx_ready <= 1'b0;
                    boot_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboarded bench for boot_loader: directed images, expected ROM writes queued, monitor compares.
module tb_boot_loader;

    localparam int HOLD = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_we;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        cpu_rst;
    logic        boot_done;
    logic        boot_err;
    logic [15:0] words_loaded;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_we_cyc = 0;

    boot_loader #(.MAX_WORDS(1024), .HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_wdata    (rom_wdata),
        .cpu_rst      (cpu_rst),
        .boot_done    (boot_done),
        .boot_err     (boot_err),
        .words_loaded (words_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every rom_we pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (rom_we) begin
            wr_t got;
            wr_t want;
            last_we_cyc = cyc;
            got.addr = rom_addr;
            got.data = rom_wdata;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", got.addr, got.data);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL rom_write: got addr %h data %h, required addr %h data %h",
                             got.addr, got.data, want.addr, want.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte has been accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            int n;
            n = $urandom_range(0, 3);
            repeat (n) begin
                rx_valid = 1'b0;
                rx_data  = 8'hee;
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: rx_ready stayed %b, required 1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] v;
        v = w;
        for (int i = 3; i >= 0; i--)
            send_byte(v[i*8 +: 8], gaps);
    endtask

    task automatic end_stream();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        end_stream();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_release(input string name);
        int t;
        t = 0;
        while (cpu_rst && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_release_timeout: cpu_rst %b, required 0", name, cpu_rst);
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset held 195 ns.
        repeat (9) begin
            @(negedge clk);
            check("rst_rx_ready", 32'(rx_ready), 32'd0);
            check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
            check("rst_rom_we", 32'(rom_we), 32'd0);
        end
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_rom_wdata", rom_wdata, 32'd0);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_boot_err", 32'(boot_err), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        #15;
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(rx_ready), 32'd1);
        @(negedge clk);

        // Nominal two-word image, back-to-back.
        exp_q.push_back('{32'h0, 32'h34011100});
        exp_q.push_back('{32'h4, 32'h34020020});
        send_word(32'h00000002, 1'b0);
        send_word(32'h34011100, 1'b0);
        send_word(32'h34020020, 1'b0);
        end_stream();
        check("nom_cpu_rst_held", 32'(cpu_rst), 32'd1);
        wait_release("nom");
        check("nom_release_delay", 32'(cyc - last_we_cyc), 32'(HOLD + 1));
        check("nom_boot_done", 32'(boot_done), 32'd1);
        check("nom_words_loaded", 32'(words_loaded), 32'd2);
        check("nom_boot_err", 32'(boot_err), 32'd0);
        check("nom_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (10) @(negedge clk);
        end_stream();
        check("nom_words_after_extra", 32'(words_loaded), 32'd2);
        check("nom_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same image with random idle gaps on rx_valid.
        do_reset();
        exp_q.push_back('{32'h0, 32'h34011100});
        exp_q.push_back('{32'h4, 32'h34020020});
        send_word(32'h00000002, 1'b1);
        send_word(32'h34011100, 1'b1);
        send_word(32'h34020020, 1'b1);
        end_stream();
        wait_release("gap");
        check("gap_boot_done", 32'(boot_done), 32'd1);
        check("gap_words_loaded", 32'(words_loaded), 32'd2);
        check("gap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero-length image.
        do_reset();
        send_word(32'h00000000, 1'b0);
        end_stream();
        check("zero_cpu_rst_held", 32'(cpu_rst), 32'd1);
        check("zero_rx_ready", 32'(rx_ready), 32'd0);
        wait_release("zero");
        check("zero_boot_done", 32'(boot_done), 32'd1);
        check("zero_words_loaded", 32'(words_loaded), 32'd0);

        // Oversize header (1025 words).
        do_reset();
        send_word(32'h00000401, 1'b0);
        end_stream();
        check("big_boot_err", 32'(boot_err), 32'd1);
        check("big_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        repeat (20) @(negedge clk);
        end_stream();
        check("big_cpu_rst", 32'(cpu_rst), 32'd1);
        check("big_boot_done", 32'(boot_done), 32'd0);
        check("big_words_loaded", 32'(words_loaded), 32'd0);

        // Upper header bits set.
        do_reset();
        send_word(32'h00010001, 1'b0);
        end_stream();
        check("hi_boot_err", 32'(boot_err), 32'd1);

        // Reset mid-load: one word plus two bytes, then async reset.
        do_reset();
        exp_q.push_back('{32'h0, 32'h34011100});
        send_word(32'h00000002, 1'b0);
        send_word(32'h34011100, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h02, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("async_rx_ready", 32'(rx_ready), 32'd0);
        check("async_cpu_rst", 32'(cpu_rst), 32'd1);
        check("async_words_loaded", 32'(words_loaded), 32'd0);
        check("async_rom_addr", rom_addr, 32'd0);
        check("async_rom_wdata", rom_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        exp_q.push_back('{32'h0, 32'h3c01abcd});
        send_word(32'h00000001, 1'b0);
        send_word(32'h3c01abcd, 1'b0);
        end_stream();
        wait_release("reload");
        check("reload_words_loaded", 32'(words_loaded), 32'd1);
        check("reload_boot_done", 32'(boot_done), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule
